adc_frame_aligner_mc: RTL and testbench

Multi-lane, parametrised frame-pattern aligner for the fast ADC LVDS receivers.
- Per lane, it compares the deserialised frame word against a programmable pattern and issues single-cycle bitslip pulses until the word matches.
- It then confirms the lock over several frames and monitors continuously, re-aligning on loss of lock.
- It sits between the LVDS deserialisers and the ADC data path and gates downstream capture through data_aligned.

---
 rtl/adc_frame_aligner_mc_pkg.sv | 22 ++
 rtl/adc_frame_aligner_mc_if.sv | 26 ++
 rtl/adc_frame_aligner_mc_lane.sv | 162 ++++++++++++++++
 rtl/adc_frame_aligner_mc.sv | 71 +++++++
 tb/tb_adc_frame_aligner_mc.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_frame_aligner_mc_pkg.sv
// Shared definitions for the ADC frame aligner.
//   - lane FSM state encoding
//   - counter width helper
//   - default frame pattern
package adc_align_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_SLIP    = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_CONFIRM = 3'd4;
  localparam logic [2:0] ST_ALIGNED = 3'd5;
  localparam logic [2:0] ST_FAIL    = 3'd6;

  localparam logic [7:0] DEFAULT_FRAME_PATTERN = 8'hF0;

  // Bits needed to hold 0..limit; never less than one bit.
  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/adc_frame_aligner_mc_if.sv
// Bus between the LVDS receiver side and the frame aligner.
//   slave  : aligner view (takes lock/realign/frame words, drives flags)
//   master : receiver/controller view
interface adc_frame_aligner_mc_if #(
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 8
);
  logic                          adc_lvds_pll_locked;
  logic                          realign;
  logic [NUM_LANES*DATA_W-1:0]   frm_data;
  logic [NUM_LANES-1:0]          bitslip;
  logic [NUM_LANES-1:0]          lane_aligned;
  logic [NUM_LANES-1:0]          lane_error;
  logic                          data_aligned;
  logic                          align_error;

  modport slave (
    input  adc_lvds_pll_locked, realign, frm_data,
    output bitslip, lane_aligned, lane_error, data_aligned, align_error
  );

  modport master (
    output adc_lvds_pll_locked, realign, frm_data,
    input  bitslip, lane_aligned, lane_error, data_aligned, align_error
  );
endinterface

// File: rtl/adc_frame_aligner_mc_lane.sv
// Single-lane frame aligner: slips the deserialiser until the frame word
// matches the pattern, confirms the lock and monitors it afterwards.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   i_pll_locked   : LVDS PLL lock (low forces IDLE)
//   i_realign      : restart request (same action as PLL loss)
//   i_frm_word     : deserialised frame word of this lane
//   o_bitslip      : registered one-cycle slip pulse
//   o_aligned      : registered lane-aligned flag
//   o_error        : registered lane-failed flag
//
// state      | meaning
// IDLE       | waiting for PLL lock
// CHECK      | compare word; match -> confirm, else slip or fail
// SLIP       | bitslip pulse is high this cycle
// SETTLE     | wait for the deserialiser to settle after a slip
// CONFIRM    | counting consecutive matches
// ALIGNED    | locked; counting consecutive misses
// FAIL       | slip budget exhausted; held until PLL loss/realign/reset
module adc_lane_aligner
  import adc_align_pkg::*;
#(
  parameter int                DATA_W        = 8,
  parameter logic [DATA_W-1:0] FRAME_PATTERN = DATA_W'(DEFAULT_FRAME_PATTERN),
  parameter int                SETTLE_CYCLES = 4,
  parameter int                CONFIRM_COUNT = 4,
  parameter int                MAX_SLIPS     = 2*DATA_W-1,
  parameter int                LOSS_COUNT    = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_pll_locked,
  input  logic              i_realign,
  input  logic [DATA_W-1:0] i_frm_word,
  output logic              o_bitslip,
  output logic              o_aligned,
  output logic              o_error
);

  localparam int SW = cnt_w(MAX_SLIPS);
  localparam int WW = cnt_w(SETTLE_CYCLES);
  localparam int MW = cnt_w(CONFIRM_COUNT);
  localparam int LW = cnt_w(LOSS_COUNT);

  localparam logic [SW-1:0] C_MAX_SLIPS = SW'(MAX_SLIPS);
  localparam logic [WW-1:0] C_SETTLE    = WW'(SETTLE_CYCLES);
  localparam logic [MW-1:0] C_CONFIRM   = MW'(CONFIRM_COUNT);
  localparam logic [LW-1:0] C_LOSS      = LW'(LOSS_COUNT);

  logic [2:0]    r_state;
  logic [SW-1:0] r_slip_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic [MW-1:0] r_match_cnt;
  logic [LW-1:0] r_miss_cnt;
  logic          r_bitslip;
  logic          r_aligned;
  logic          r_error;

  logic          w_match;
  logic [WW-1:0] w_wait_nxt;
  logic [MW-1:0] w_match_nxt;
  logic [LW-1:0] w_miss_nxt;

  assign w_match     = (i_frm_word == FRAME_PATTERN);
  assign w_wait_nxt  = r_wait_cnt - WW'(1);
  assign w_match_nxt = r_match_cnt + MW'(1);
  assign w_miss_nxt  = r_miss_cnt + LW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_slip_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_bitslip   <= 1'b0;
      r_aligned   <= 1'b0;
      r_error     <= 1'b0;
    end else if (!i_pll_locked || i_realign) begin
      // Dropping out of SETTLE here also drops any pending slip.
      r_state     <= ST_IDLE;
      r_slip_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_bitslip   <= 1'b0;
      r_aligned   <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_bitslip <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_slip_cnt <= '0;
          r_state    <= ST_CHECK;
        end
        ST_CHECK: begin
          if (w_match) begin
            r_match_cnt <= MW'(1);
            if (CONFIRM_COUNT == 1) begin
              r_aligned  <= 1'b1;
              r_miss_cnt <= '0;
              r_state    <= ST_ALIGNED;
            end else begin
              r_state <= ST_CONFIRM;
            end
          end else if (r_slip_cnt == C_MAX_SLIPS) begin
            r_error <= 1'b1;
            r_state <= ST_FAIL;
          end else begin
            // Registered pulse: high for exactly the SLIP cycle.
            r_bitslip <= 1'b1;
            r_state   <= ST_SLIP;
          end
        end
        ST_SLIP: begin
          r_slip_cnt <= r_slip_cnt + SW'(1);
          r_wait_cnt <= C_SETTLE;
          r_state    <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_wait_cnt <= w_wait_nxt;
          if (w_wait_nxt == '0) r_state <= ST_CHECK;
        end
        ST_CONFIRM: begin
          if (w_match) begin
            r_match_cnt <= w_match_nxt;
            if (w_match_nxt == C_CONFIRM) begin
              r_aligned  <= 1'b1;
              r_miss_cnt <= '0;
              r_state    <= ST_ALIGNED;
            end
          end else begin
            // slip_cnt is kept so a repeat mismatch in CHECK slips again.
            r_state <= ST_CHECK;
          end
        end
        ST_ALIGNED: begin
          if (w_match) begin
            r_miss_cnt <= '0;
          end else if (w_miss_nxt == C_LOSS) begin
            r_aligned  <= 1'b0;
            r_miss_cnt <= '0;
            r_slip_cnt <= '0;
            r_state    <= ST_CHECK;
          end else begin
            r_miss_cnt <= w_miss_nxt;
          end
        end
        ST_FAIL: begin
          r_error   <= 1'b1;
          r_aligned <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_bitslip = r_bitslip;
  assign o_aligned = r_aligned;
  assign o_error   = r_error;

endmodule

// File: rtl/adc_frame_aligner_mc.sv
// Multi-lane frame-pattern aligner for the fast ADC LVDS receivers.
// One independent lane aligner per lane plus registered aggregates.
// Ports:
//   clk, reset_n : deserialiser parallel clock, async active-low reset
//   bus (slave)  : adc_lvds_pll_locked, realign, frm_data in;
//                  bitslip, lane_aligned, lane_error, data_aligned,
//                  align_error out
module adc_frame_aligner_mc
  import adc_align_pkg::*;
#(
  parameter int                NUM_LANES     = 2,
  parameter int                DATA_W        = 8,
  parameter logic [DATA_W-1:0] FRAME_PATTERN = DATA_W'(DEFAULT_FRAME_PATTERN),
  parameter int                SETTLE_CYCLES = 4,
  parameter int                CONFIRM_COUNT = 4,
  parameter int                MAX_SLIPS     = 2*DATA_W-1,
  parameter int                LOSS_COUNT    = 3
) (
  input logic                   clk,
  input logic                   reset_n,
  adc_frame_aligner_mc_if.slave bus
);

  logic [NUM_LANES-1:0] w_bitslip;
  logic [NUM_LANES-1:0] w_lane_aligned;
  logic [NUM_LANES-1:0] w_lane_error;
  logic                 r_data_aligned;
  logic                 r_align_error;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    adc_lane_aligner #(
      .DATA_W        (DATA_W),
      .FRAME_PATTERN (FRAME_PATTERN),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .CONFIRM_COUNT (CONFIRM_COUNT),
      .MAX_SLIPS     (MAX_SLIPS),
      .LOSS_COUNT    (LOSS_COUNT)
    ) u_lane (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_pll_locked (bus.adc_lvds_pll_locked),
      .i_realign    (bus.realign),
      .i_frm_word   (bus.frm_data[g*DATA_W +: DATA_W]),
      .o_bitslip    (w_bitslip[g]),
      .o_aligned    (w_lane_aligned[g]),
      .o_error      (w_lane_error[g])
    );
  end

  // Aggregates also clear on PLL loss/realign so every output is 0
  // on the cycle after the event, not two cycles later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_aligned <= 1'b0;
      r_align_error  <= 1'b0;
    end else if (!bus.adc_lvds_pll_locked || bus.realign) begin
      r_data_aligned <= 1'b0;
      r_align_error  <= 1'b0;
    end else begin
      r_data_aligned <= &w_lane_aligned;
      r_align_error  <= |w_lane_error;
    end
  end

  assign bus.bitslip      = w_bitslip;
  assign bus.lane_aligned = w_lane_aligned;
  assign bus.lane_error   = w_lane_error;
  assign bus.data_aligned = r_data_aligned;
  assign bus.align_error  = r_align_error;

endmodule

// File: tb/tb_adc_frame_aligner_mc.sv
// Bench for adc_frame_aligner_mc: table vectors, randomized runs against
// a closed-form timing model, and hand sequences for loss/PLL/reset cases.
module tb_adc_frame_aligner_mc;
  import adc_align_pkg::*;

  localparam int         NL  = 2;
  localparam int         DW  = 8;
  localparam int         S   = 4;
  localparam int         CC  = 4;
  localparam int         MS  = 15;
  localparam int         LC  = 3;
  localparam logic [7:0] PAT = 8'hF0;
  localparam int         P   = S + 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  adc_frame_aligner_mc_if #(.NUM_LANES(NL), .DATA_W(DW)) bus ();

  adc_frame_aligner_mc #(
    .NUM_LANES(NL), .DATA_W(DW), .FRAME_PATTERN(PAT), .SETTLE_CYCLES(S),
    .CONFIRM_COUNT(CC), .MAX_SLIPS(MS), .LOSS_COUNT(LC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    int         mode;
    int         slips0;
    int         slips1;
    logic [1:0] aligned;
    logic [1:0] error;
  } vec_t;

  vec_t       vecs[6];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] des[NL];

  function automatic logic [7:0] rol(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int j = 0; j < n; j++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic int slips_needed(input logic [7:0] v);
    for (int j = 0; j < 8; j++) if (rol(v, j) == PAT) return j;
    return -1;
  endfunction

  function automatic logic [7:0] outs();
    return {bus.bitslip, bus.lane_aligned, bus.lane_error,
            bus.data_aligned, bus.align_error};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    bus.frm_data = {des[1], des[0]};
  endtask

  // Deserialiser model: each observed bitslip rotates that lane's word left.
  task automatic step_model();
    for (int i = 0; i < NL; i++) if (bus.bitslip[i]) des[i] = rol(des[i], 1);
    drive();
  endtask

  // Leaves the lanes so that the next posedge takes them IDLE -> CHECK.
  task automatic restart(input int mode);
    case (mode)
      0: begin
        bus.adc_lvds_pll_locked = 1'b0;
        @(negedge clk);
        bus.adc_lvds_pll_locked = 1'b1;
      end
      1: begin
        bus.realign = 1'b1;
        @(negedge clk);
        bus.realign = 1'b0;
      end
      default: bus.adc_lvds_pll_locked = 1'b1;
    endcase
  endtask

  // Every cycle checked against closed-form timing derived from slip count.
  task automatic check_run(input logic [7:0] a, input logic [7:0] b,
                           input int mode, input int ncyc);
    int k[NL], ns[NL], t_al[NL], t_er, t_da;
    bit ok[NL], all_ok, any_bad;
    logic [1:0] e_bs, e_al, e_er;
    logic e_da, e_ae;
    des[0] = a; des[1] = b; drive();
    restart(mode);
    t_er = 2 + MS*P;
    all_ok = 1; any_bad = 0; t_da = 0;
    for (int i = 0; i < NL; i++) begin
      k[i]    = slips_needed(des[i]);
      ok[i]   = (k[i] >= 0);
      ns[i]   = ok[i] ? k[i] : MS;
      t_al[i] = 1 + k[i]*P + CC;
      if (!ok[i]) begin all_ok = 0; any_bad = 1; end
      else if (t_al[i] > t_da) t_da = t_al[i];
    end
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < NL; i++) begin
        e_bs[i] = (c >= 2) && ((c-2) % P == 0) && ((c-2) / P < ns[i]);
        e_al[i] = ok[i] && (c >= t_al[i]);
        e_er[i] = !ok[i] && (c >= t_er);
      end
      e_da = all_ok && (c >= t_da + 1);
      e_ae = any_bad && (c >= t_er + 1);
      check($sformatf("run %h/%h cyc%0d", a, b, c), outs(), {e_bs, e_al, e_er, e_da, e_ae});
      step_model();
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int cnt[NL], last[NL];
    des[0] = v.w0; des[1] = v.w1; drive();
    restart(v.mode);
    for (int i = 0; i < NL; i++) begin cnt[i] = 0; last[i] = -1; end
    for (int c = 1; c <= 110; c++) begin
      @(negedge clk);
      for (int i = 0; i < NL; i++) if (bus.bitslip[i]) begin
        if (last[i] >= 0) check($sformatf("vec%0d spacing lane%0d", idx, i), c - last[i], P);
        last[i] = c;
        cnt[i]++;
      end
      step_model();
    end
    check($sformatf("vec%0d slips0", idx), cnt[0], v.slips0);
    check($sformatf("vec%0d slips1", idx), cnt[1], v.slips1);
    check($sformatf("vec%0d lane_aligned", idx), bus.lane_aligned, v.aligned);
    check($sformatf("vec%0d lane_error", idx), bus.lane_error, v.error);
    check($sformatf("vec%0d data_aligned", idx), bus.data_aligned, (v.aligned == 2'b11));
    check($sformatf("vec%0d align_error", idx), bus.align_error, (v.error != 2'b00));
  endtask

  initial begin
    int cnt, pulses;
    logic [7:0] a, b;

    vecs[0] = '{8'hF0, 8'hF0, 2,  0,  0, 2'b11, 2'b00};
    vecs[1] = '{8'h1E, 8'hF0, 1,  3,  0, 2'b11, 2'b00};
    vecs[2] = '{8'hF0, 8'hAA, 1,  0, 15, 2'b01, 2'b10};
    vecs[3] = '{8'hF0, 8'hAA, 1,  0, 15, 2'b01, 2'b10};
    vecs[4] = '{8'hE1, 8'h78, 0,  7,  1, 2'b11, 2'b00};
    vecs[5] = '{8'h00, 8'h0F, 1, 15,  4, 2'b10, 2'b01};

    reset_n = 1'b0;
    bus.adc_lvds_pll_locked = 1'b0;
    bus.realign = 1'b0;
    des[0] = 8'h00; des[1] = 8'h00; drive();
    repeat (3) @(negedge clk);
    check("reset outputs", outs(), 8'h00);
    reset_n = 1'b1;
    @(negedge clk);
    check("pll low outputs", outs(), 8'h00);

    foreach (vecs[v]) apply_vec(vecs[v], v);

    for (int t = 0; t < 12; t++) begin
      if (t % 2 == 0) begin
        a = rol(PAT, $urandom_range(0, 7));
        b = rol(PAT, $urandom_range(0, 7));
      end else begin
        a = 8'($urandom_range(0, 255));
        b = rol(PAT, $urandom_range(0, 7));
        if (t % 4 == 3) b = 8'($urandom_range(0, 255));
      end
      check_run(a, b, t % 2, 100);
    end

    // Miss tolerance, then loss of lock with slip budget restarted.
    check_run(8'h1E, 8'hF0, 1, 40);
    des[0] = 8'h00; drive();
    @(negedge clk); step_model();
    @(negedge clk); des[0] = PAT; drive();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("two misses hold c%0d", c), bus.lane_aligned, 2'b11);
      step_model();
    end
    des[0] = 8'hAA; drive();
    @(negedge clk); check("loss miss1", bus.lane_aligned, 2'b11); step_model();
    @(negedge clk); check("loss miss2", bus.lane_aligned, 2'b11); step_model();
    @(negedge clk); check("loss drop", bus.lane_aligned, 2'b10); step_model();
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) check("loss resume slip", bus.bitslip, 2'b01);
      if (bus.bitslip[0]) cnt++;
      step_model();
    end
    check("loss fresh slips", cnt, MS);
    check("loss lane flags", {bus.lane_aligned, bus.lane_error}, {2'b10, 2'b01});

    // PLL drop in SETTLE after the second slip.
    des[0] = 8'h1E; des[1] = PAT; drive();
    restart(1);
    pulses = 0;
    for (int c = 0; c < 40 && pulses < 2; c++) begin
      @(negedge clk);
      if (bus.bitslip[0]) pulses++;
      step_model();
    end
    check("pll test pulses", pulses, 2);
    @(negedge clk);
    check("pre pll drop", {bus.bitslip, bus.lane_aligned}, {2'b00, 2'b10});
    bus.adc_lvds_pll_locked = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("pll drop clear c%0d", c), outs(), 8'h00);
      step_model();
    end
    check_run(des[0], des[1], 2, 60);

    // Asynchronous reset mid-CONFIRM of lane 1.
    des[0] = PAT; des[1] = 8'h1E; drive();
    restart(0);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      step_model();
    end
    check("pre reset", {bus.bitslip, bus.lane_aligned}, {2'b00, 2'b01});
    #2 reset_n = 1'b0;
    #1 check("async reset clear", outs(), 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    check_run(des[0], des[1], 2, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
